uart_tx_stream: RTL and testbench
=================================

# uart_tx_stream

Serial transmitter that drains bytes from the output side of the stream FIFO and emits them as asynchronous UART frames (start, data LSB-first, optional parity, stop). It sits directly downstream of the FIFO. It drives the FIFO's ready input, consumes the FIFO's data/valid pair, and owns the board TX pin.

## Interface
- CLKS_PER_BIT, 868: i_clk cycles per serial bit; legal values ≥ 2.
- DATA_BITS, 8: data bits per frame, 5–8.
- PARITY_EN, 0: 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd; ignored when PARITY_EN=0.
- STOP_BITS, 1: number of stop bits, 1 or 2.
- i_clk  in  1  system clock.
- i_reset  in  1  reset; synchronous, active-high. Clock is i_clk.
- i_tx_en  in  1  when low, no new byte is requested; an in-flight frame completes.
- i_data  in  DATA_BITS  byte from FIFO data output.
- i_data_valid  in  1  FIFO output-valid.
- o_ready  out  1  ready to FIFO output side.
- o_tx  out  1  serial line; idles high.
- o_busy  out  1  high in every state except IDLE.
- o_frame_done  out  1  one-cycle pulse when the final stop bit ends.

## Operation
- Reset values: o_tx=1, o_ready=0, o_busy=0, o_frame_done=0. State is IDLE, and the bit counter and baud counter are 0.
- States: IDLE, REQUEST, HOLD, START, DATA, PARITY, STOP.
- IDLE → REQUEST when i_tx_en=1 and i_data_valid=0. The valid=0 guard ensures the previous transfer has been released.
- REQUEST: o_ready=1. Moves to HOLD when i_data_valid is sampled 1. If i_tx_en drops while still in REQUEST, the block returns to IDLE.
- HOLD: o_ready=1 for exactly one cycle so that the FIFO's registered data settles. On leaving HOLD, i_data is latched into the shift register, parity is computed from the latched byte, and the next state is START. o_ready=0 from START onward.
- START: o_tx=0 for CLKS_PER_BIT cycles.
- DATA: shift-register LSB is driven on o_tx. The register shifts right every CLKS_PER_BIT cycles for DATA_BITS bits.
- PARITY (present only when PARITY_EN=1): o_tx = XOR of the data bits, XOR PARITY_ODD, for CLKS_PER_BIT cycles.
- STOP: o_tx=1 for STOP_BITS×CLKS_PER_BIT cycles. Then o_frame_done=1 for one cycle and the state returns to IDLE.
- Baud counter: width $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1, wraps to 0 at the bit boundary, and is cleared on entry to START.
- Bit counter: width $clog2(DATA_BITS+1). It counts data bits and is reused for stop bits.
- The block never re-requests while i_data_valid is still high from the previous word.
- i_data and i_data_valid are ignored outside REQUEST and HOLD.

## Timing
- Edge E0: i_data_valid sampled 1 in REQUEST, so the state becomes HOLD.
- Edge E1: byte latched, state becomes START, o_tx becomes 0, o_ready becomes 0.
- Frame length from E1 is (1 + DATA_BITS + PARITY_EN + STOP_BITS) × CLKS_PER_BIT cycles. o_frame_done is high in the cycle after the last stop-bit cycle.
- Back-to-back operation: if the FIFO is non-empty and i_tx_en=1, the gap between frames is at least 2 cycles (IDLE, REQUEST) plus the HOLD cycle. o_tx stays 1 throughout the gap.
- Reset mid-frame: on the next edge o_tx=1, o_ready=0, and state is IDLE. The partial frame is abandoned.
- Reset in HOLD: the word is dropped. The FIFO shares i_reset, so both sides restart together.
- i_tx_en falling during START, DATA, PARITY or STOP has no effect until IDLE.
- CLKS_PER_BIT=2 must work: each bit lasts 2 cycles and there is no off-by-one.

## Test plan
- Reset: assert i_reset for 3 cycles with i_data_valid=1. Required: o_tx=1, o_ready=0, o_busy=0 throughout, and o_ready=0 until one cycle after reset is released.
- 8N1 with CLKS_PER_BIT=4: offer 0xA5. Required: o_tx sequence per 4-cycle bit is 0,1,0,1,0,0,1,0,1,1. o_frame_done pulses exactly 40 cycles after E1.
- 8E2 with CLKS_PER_BIT=4: send 0xA5, then 0x07. Required: parity bit is 0 for 0xA5 and 1 for 0x07, and each frame has 8 stop-cycles high.
- FIFO integration: write 0x11, 0x22, 0x33 into the FIFO with i_tx_en=1. Required: three frames in order, no duplicate and no skipped byte, o_ready never high while o_busy is in START through STOP, and the FIFO reports empty after the third latch.
- Flow control: deassert i_tx_en mid-DATA of the first byte. Required: that frame completes, no further o_ready until i_tx_en returns to 1, then the second byte is sent.
- Reset mid-frame: assert i_reset during data bit 3 of 0xFF. Required: o_tx=1 on the next edge, no o_frame_done pulse, and a clean new frame after re-enable.

Source files
------------

// File: rtl/uart_tx_stream.sv
// uart_tx_stream: drains words from the stream FIFO output and sends them as
// asynchronous UART frames (start, data LSB-first, optional parity, stop).
// The FIFO handshake is REQUEST (ready, wait for valid) then one HOLD cycle
// (ready still high) so the FIFO's registered data settles before the latch.
module uart_tx_stream #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_tx_en,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_data_valid,
  output logic                 o_ready,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_frame_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQUEST = 3'd1,
    HOLD    = 3'd2,
    START   = 3'd3,
    DATA    = 3'd4,
    PARITY  = 3'd5,
    STOP    = 3'd6
  } state_t;

  state_t               state;
  logic [BAUD_W-1:0]    baud_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 bit_end;

  // Last cycle of the current serial bit.
  assign bit_end = (baud_cnt == BAUD_LAST);

  // Frame sequencer; every output is registered and changes on the bit edge
  // together with the state, so o_tx never glitches between bits.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= IDLE;
      baud_cnt     <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      par_bit      <= 1'b0;
      o_tx         <= 1'b1;
      o_ready      <= 1'b0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          // valid must have dropped, otherwise the previous word is still
          // being presented and asking again would duplicate it
          if (i_tx_en && !i_data_valid) begin
            state   <= REQUEST;
            o_ready <= 1'b1;
            o_busy  <= 1'b1;
          end
        end
        REQUEST: begin
          // a sampled valid is a completed handshake, so it wins over a
          // simultaneous enable drop to avoid losing a popped word
          if (i_data_valid) begin
            state <= HOLD;
          end else if (!i_tx_en) begin
            state   <= IDLE;
            o_ready <= 1'b0;
            o_busy  <= 1'b0;
          end
        end
        HOLD: begin
          shreg    <= i_data;
          par_bit  <= (^i_data) ^ (PARITY_ODD != 0);
          state    <= START;
          o_ready  <= 1'b0;
          o_tx     <= 1'b0;
          baud_cnt <= '0;
          bit_cnt  <= '0;
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            state    <= DATA;
            o_tx     <= shreg[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            shreg    <= {1'b0, shreg[DATA_BITS-1:1]};
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              if (PARITY_EN != 0) begin
                state <= PARITY;
                o_tx  <= par_bit;
              end else begin
                state <= STOP;
                o_tx  <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              o_tx    <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (bit_end) begin
            baud_cnt <= '0;
            state    <= STOP;
            o_tx     <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_cnt == STOP_LAST) begin
              bit_cnt      <= '0;
              state        <= IDLE;
              o_busy       <= 1'b0;
              o_frame_done <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          o_tx    <= 1'b1;
          o_ready <= 1'b0;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Bench for uart_tx_stream: three instances (8N1/4, 8E2/4, 7O1/2) fed by a
// small FIFO-like source; a monitor decodes every frame cycle by cycle and
// compares against hand-written expected frames queued by the stimulus.
module tb_uart_tx_stream;

  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic [2:0] tx_en  = 3'b111;
  logic [2:0] dvalid = 3'b111;
  logic [7:0] data0  = '0;
  logic [7:0] data1  = '0;
  logic [6:0] data2  = '0;
  logic [2:0] tx, rdy, busy, done;

  always #5 clk = ~clk;

  uart_tx_stream #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
    .i_clk(clk), .i_reset(rst), .i_tx_en(tx_en[0]), .i_data(data0), .i_data_valid(dvalid[0]),
    .o_ready(rdy[0]), .o_tx(tx[0]), .o_busy(busy[0]), .o_frame_done(done[0]));

  uart_tx_stream #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut1 (
    .i_clk(clk), .i_reset(rst), .i_tx_en(tx_en[1]), .i_data(data1), .i_data_valid(dvalid[1]),
    .o_ready(rdy[1]), .o_tx(tx[1]), .o_busy(busy[1]), .o_frame_done(done[1]));

  uart_tx_stream #(.CLKS_PER_BIT(2), .DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut2 (
    .i_clk(clk), .i_reset(rst), .i_tx_en(tx_en[2]), .i_data(data2), .i_data_valid(dvalid[2]),
    .o_ready(rdy[2]), .o_tx(tx[2]), .o_busy(busy[2]), .o_frame_done(done[2]));

  // words waiting in the modelled FIFO, and expected frames (bit i = serial bit i)
  logic [7:0]  src_q0[$], src_q1[$], src_q2[$];
  logic [11:0] exp_q0[$], exp_q1[$], exp_q2[$];

  int   cmp_cnt   = 0;
  int   fail_cnt  = 0;
  int   to_cnt    = 0;
  logic final_req = 1'b0;
  logic final_ack = 1'b0;

  function automatic int cpb(input int g);
    return (g == 2) ? 2 : 4;
  endfunction

  function automatic int nbits(input int g);
    return (g == 1) ? 12 : 10;
  endfunction

  function automatic int src_size(input int g);
    case (g)
      0: return src_q0.size();
      1: return src_q1.size();
      default: return src_q2.size();
    endcase
  endfunction

  function automatic int exp_size(input int g);
    case (g)
      0: return exp_q0.size();
      1: return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  task automatic send(input int g, input logic [7:0] b, input logic [11:0] fr);
    case (g)
      0: begin src_q0.push_back(b); exp_q0.push_back(fr); end
      1: begin src_q1.push_back(b); exp_q1.push_back(fr); end
      default: begin src_q2.push_back(b); exp_q2.push_back(fr); end
    endcase
  endtask

  // FIFO-side model: stale valid through reset and one cycle after, offers a
  // word only while ready is high, withdraws it once ready falls (latched).
  int sst [3] = '{2, 2, 2};
  always @(negedge clk) begin
    logic [7:0] b;
    for (int g = 0; g < 3; g++) begin
      if (rst) begin
        dvalid[g] = 1'b1;
        sst[g]    = 2;
      end else begin
        case (sst[g])
          2: sst[g] = 0;
          1: if (!rdy[g]) begin dvalid[g] = 1'b0; sst[g] = 0; end
          default: begin
            dvalid[g] = 1'b0;
            if (rdy[g] && src_size(g) > 0) begin
              dvalid[g] = 1'b1;
              sst[g]    = 1;
              case (g)
                0: data0 = src_q0.pop_front();
                1: data1 = src_q1.pop_front();
                default: begin b = src_q2.pop_front(); data2 = b[6:0]; end
              endcase
            end
          end
        endcase
      end
    end
  end

  // reset / enable as seen by the DUT at its last two edges
  logic       rst_q  = 1'b1;
  logic       rst_q2 = 1'b1;
  logic [2:0] en_q   = 3'b111;
  logic [2:0] en_q2  = 3'b111;
  always @(posedge clk) begin
    rst_q2 <= rst_q;
    rst_q  <= rst;
    en_q2  <= en_q;
    en_q   <= tx_en;
  end

  // Monitor / scoreboard
  logic [2:0]  in_fr = '0;
  logic [2:0]  bad   = '0;
  int          cyc [3];
  logic [11:0] cur [3];
  logic [11:0] got [3];
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (rst_q) begin
        cmp_cnt++;
        if (tx[g] !== 1'b1 || rdy[g] !== 1'b0 || busy[g] !== 1'b0 || done[g] !== 1'b0) begin
          fail_cnt++;
          $display("FAIL reset_state dut%0d: tx=%b ready=%b busy=%b done=%b, required 1 0 0 0",
                   g, tx[g], rdy[g], busy[g], done[g]);
        end
        in_fr[g] = 1'b0;
      end else begin
        if (rst_q2) begin
          cmp_cnt++;
          if (rdy[g] !== 1'b0) begin
            fail_cnt++;
            $display("FAIL ready_after_reset dut%0d: ready=%b, required 0", g, rdy[g]);
          end
        end
        if (!en_q[g] && !en_q2[g]) begin
          cmp_cnt++;
          if (rdy[g] !== 1'b0) begin
            fail_cnt++;
            $display("FAIL ready_while_disabled dut%0d: ready=%b, required 0", g, rdy[g]);
          end
        end
        if (!in_fr[g]) begin
          cmp_cnt++;
          if (done[g] !== 1'b0) begin
            fail_cnt++;
            $display("FAIL spurious_done dut%0d: frame_done=%b outside frame end, required 0", g, done[g]);
          end
          if (tx[g] === 1'b0) begin
            in_fr[g] = 1'b1;
            cyc[g]   = 0;
            bad[g]   = 1'b0;
            got[g]   = '0;
            cmp_cnt++;
            if (exp_size(g) == 0) begin
              fail_cnt++;
              $display("FAIL unexpected_frame dut%0d: frame started with 0 expected, required none", g);
              cur[g] = '0;
            end else begin
              case (g)
                0: cur[g] = exp_q0.pop_front();
                1: cur[g] = exp_q1.pop_front();
                default: cur[g] = exp_q2.pop_front();
              endcase
            end
          end
        end
        if (in_fr[g]) begin
          if (cyc[g] < nbits(g) * cpb(g)) begin
            if (tx[g] !== cur[g][cyc[g] / cpb(g)] || rdy[g] !== 1'b0 ||
                done[g] !== 1'b0 || busy[g] !== 1'b1)
              bad[g] = 1'b1;
            if (cyc[g] % cpb(g) == cpb(g) / 2)
              got[g][cyc[g] / cpb(g)] = tx[g];
            cyc[g]++;
          end else begin
            cmp_cnt++;
            if (bad[g]) begin
              fail_cnt++;
              $display("FAIL frame_bits dut%0d: serial bits %h (mid-bit), required %h, every cycle with ready=0 busy=1",
                       g, got[g], cur[g]);
            end
            cmp_cnt++;
            if (done[g] !== 1'b1) begin
              fail_cnt++;
              $display("FAIL frame_done_timing dut%0d: frame_done=%b at cycle %0d after latch, required 1",
                       g, done[g], cyc[g]);
            end
            in_fr[g] = 1'b0;
          end
        end
      end
    end
    if (final_req && !final_ack) begin
      cmp_cnt++;
      if (to_cnt != 0) begin
        fail_cnt++;
        $display("FAIL wait_timeout: %0d bounded waits expired, required 0", to_cnt);
      end
      for (int g = 0; g < 3; g++) begin
        cmp_cnt++;
        if (src_size(g) != 0 || exp_size(g) != 0 || in_fr[g]) begin
          fail_cnt++;
          $display("FAIL drain dut%0d: fifo=%0d expected_left=%0d in_frame=%b, required 0 0 0",
                   g, src_size(g), exp_size(g), in_fr[g]);
        end
      end
      final_ack = 1'b1;
    end
  end

  task automatic wait_drain(input int maxc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (src_size(0) == 0 && src_size(1) == 0 && src_size(2) == 0 &&
          exp_size(0) == 0 && exp_size(1) == 0 && exp_size(2) == 0 && in_fr == 3'b000) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) to_cnt++;
  endtask

  task automatic wait_start(input int g, input int maxc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (tx[g] === 1'b0) begin ok = 1'b1; break; end
    end
    if (!ok) to_cnt++;
  endtask

  initial begin
    // reset for 3 edges with the source holding valid high
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 8N1 A5, 8E2 A5/07 (parity 0/1), 7O1 55/01 (parity 1/0)
    send(0, 8'hA5, {2'b00, 1'b1, 8'hA5, 1'b0});
    send(1, 8'hA5, {2'b11, 1'b0, 8'hA5, 1'b0});
    send(1, 8'h07, {2'b11, 1'b1, 8'h07, 1'b0});
    send(2, 8'h55, {2'b00, 1'b1, 1'b1, 7'h55, 1'b0});
    send(2, 8'h01, {2'b00, 1'b1, 1'b0, 7'h01, 1'b0});
    wait_drain(600);

    // back-to-back burst through the FIFO model
    send(0, 8'h11, {2'b00, 1'b1, 8'h11, 1'b0});
    send(0, 8'h22, {2'b00, 1'b1, 8'h22, 1'b0});
    send(0, 8'h33, {2'b00, 1'b1, 8'h33, 1'b0});
    wait_drain(600);

    // flow control: enable drops mid-DATA of the first byte
    send(0, 8'h3C, {2'b00, 1'b1, 8'h3C, 1'b0});
    send(0, 8'hC3, {2'b00, 1'b1, 8'hC3, 1'b0});
    wait_start(0, 200);
    repeat (10) @(posedge clk);
    #1 tx_en[0] = 1'b0;
    repeat (100) @(posedge clk);
    #1 tx_en[0] = 1'b1;
    wait_drain(400);

    // reset during data bit 3 of 0xFF, then a clean frame
    send(0, 8'hFF, {2'b00, 1'b1, 8'hFF, 1'b0});
    wait_start(0, 200);
    repeat (17) @(posedge clk);
    #1 begin rst = 1'b1; tx_en = 3'b000; end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 tx_en = 3'b111;
    send(0, 8'h5A, {2'b00, 1'b1, 8'h5A, 1'b0});
    wait_drain(400);

    final_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      if (final_ack) break;
    end
    if (!final_ack) begin
      $display("FAIL final_check: monitor did not complete, required completion");
      $fatal(1, "monitor stalled");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
